// File: rtl/bilberry_mem_pkg.sv
// Shared types and widths for the BRAM load/store path.
package bilberry_mem_pkg;

   localparam int RAM_DW  = 32;
   localparam int RAM_AW  = 15;
   localparam int BADDR_W = 17;
   localparam int CNT_W   = 4;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_BAD  = 2'b11
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      RD_WAIT,
      WRITE
   } lsu_state_t;

endpackage

// File: rtl/ram_lane_align.sv
// Lane extract/extend for loads and lane merge for read-modify-write stores.
module ram_lane_align
   import bilberry_mem_pkg::*;
(
   input  mem_size_t         size,
   input  logic [1:0]        offset,
   input  logic              sign_ext,
   input  logic [RAM_DW-1:0] word,
   input  logic [RAM_DW-1:0] wdata,
   output logic [RAM_DW-1:0] load_data,
   output logic [RAM_DW-1:0] merged
);

   logic [4:0] sh_b;
   logic [4:0] sh_h;
   logic [7:0] byte_lane;
   logic [15:0] half_lane;

   assign sh_b      = {offset, 3'b000};
   assign sh_h      = {offset[1], 4'b0000};
   assign byte_lane = word[sh_b +: 8];
   assign half_lane = word[sh_h +: 16];

   always_comb begin
      load_data = word;
      merged    = wdata;
      case (size)
         SZ_BYTE: begin
            load_data           = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            merged              = word;
            merged[sh_b +: 8]   = wdata[7:0];
         end
         SZ_HALF: begin
            load_data           = {{16{sign_ext & half_lane[15]}}, half_lane};
            merged              = word;
            merged[sh_h +: 16]  = wdata[15:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/bram_lsu.sv
// Byte/half/word load-store initiator on a 32-bit word BRAM port.
//
// state   | meaning
// IDLE    | ready for a request; illegal requests answered from here
// READ    | word address driven, startReadRAM pulsed
// RD_WAIT | waiting for readRdyRAM; load returns or store merges
// WRITE   | address/data held, we follows saveRdyRAM
module bram_lsu
   import bilberry_mem_pkg::*;
#(
   parameter int BLOCKS  = 14,
   parameter int TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_we,
   input  logic [1:0]         req_size,
   input  logic               req_signed,
   input  logic [BADDR_W-1:0] req_addr,
   input  logic [RAM_DW-1:0]  req_wdata,
   output logic               resp_valid,
   output logic [RAM_DW-1:0]  resp_rdata,
   output logic               resp_err,
   output logic [RAM_AW-1:0]  addr,
   output logic [RAM_DW-1:0]  din,
   output logic               we,
   output logic               startReadRAM,
   input  logic [RAM_DW-1:0]  out,
   input  logic               readRdyRAM,
   input  logic               saveRdyRAM
);

   localparam logic [31:0]      WORD_LIMIT = 32'(BLOCKS * 256);
   localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_TC     = CNT_W'(1);

   lsu_state_t        state;
   lsu_state_t        nxt_state;
   mem_size_t         lat_size;
   logic              lat_signed;
   logic              lat_we;
   logic [1:0]        lat_off;
   logic [CNT_W-1:0]  cnt;

   logic              accept;
   logic              req_ok;
   logic              size_ok;
   logic              align_ok;
   logic              range_ok;
   logic              resp_set;
   logic              err_set;
   logic              load_done;
   logic              merge_en;
   logic              cnt_load;
   logic              cnt_dec;
   logic [RAM_DW-1:0] load_data;
   logic [RAM_DW-1:0] merged;

   assign req_ready = rst & (state == IDLE);
   assign accept    = req_valid & req_ready;
   // Gated by rst so a reset landing in WRITE can never commit the store.
   assign we        = rst & (state == WRITE) & saveRdyRAM;

   always_comb begin
      size_ok  = 1'b1;
      align_ok = 1'b1;
      case (mem_size_t'(req_size))
         SZ_HALF: align_ok = ~req_addr[0];
         SZ_WORD: align_ok = (req_addr[1:0] == 2'b00);
         SZ_BAD:  size_ok  = 1'b0;
         default: ;
      endcase
   end

   assign range_ok = 32'(req_addr[BADDR_W-1:2]) < WORD_LIMIT;
   assign req_ok   = size_ok & align_ok & range_ok;

   always_comb begin
      nxt_state = state;
      resp_set  = 1'b0;
      err_set   = 1'b0;
      load_done = 1'b0;
      merge_en  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (!req_ok) begin
                  resp_set = 1'b1;
                  err_set  = 1'b1;
               end else if (req_we && (mem_size_t'(req_size) == SZ_WORD)) begin
                  nxt_state = WRITE;
               end else begin
                  nxt_state = READ;
               end
            end
         end
         READ: nxt_state = RD_WAIT;
         RD_WAIT: begin
            if (readRdyRAM) begin
               if (lat_we) begin
                  merge_en  = 1'b1;
                  nxt_state = WRITE;
               end else begin
                  load_done = 1'b1;
                  resp_set  = 1'b1;
                  nxt_state = IDLE;
               end
            end else if (cnt == CNT_TC) begin
               resp_set  = 1'b1;
               err_set   = 1'b1;
               nxt_state = IDLE;
            end
         end
         WRITE: begin
            if (saveRdyRAM) begin
               resp_set  = 1'b1;
               nxt_state = IDLE;
            end else if (cnt == CNT_TC) begin
               resp_set  = 1'b1;
               err_set   = 1'b1;
               nxt_state = IDLE;
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   // Timer reloads on entry to a wait state and counts down each stalled cycle.
   assign cnt_load = (nxt_state != state) && ((nxt_state == RD_WAIT) || (nxt_state == WRITE));
   assign cnt_dec  = ((state == RD_WAIT) && !readRdyRAM) || ((state == WRITE) && !saveRdyRAM);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         addr         <= '0;
         din          <= '0;
         resp_valid   <= 1'b0;
         resp_err     <= 1'b0;
         resp_rdata   <= '0;
         startReadRAM <= 1'b0;
         cnt          <= '0;
         lat_size     <= SZ_BYTE;
         lat_signed   <= 1'b0;
         lat_we       <= 1'b0;
         lat_off      <= 2'b00;
      end else begin
         state        <= nxt_state;
         resp_valid   <= resp_set;
         resp_err     <= err_set;
         resp_rdata   <= load_done ? load_data : '0;
         startReadRAM <= (nxt_state == READ);
         if (accept && req_ok) begin
            addr       <= req_addr[BADDR_W-1:2];
            din        <= req_wdata;
            lat_size   <= mem_size_t'(req_size);
            lat_signed <= req_signed;
            lat_we     <= req_we;
            lat_off    <= req_addr[1:0];
         end
         if (merge_en) begin
            din <= merged;
         end
         if (cnt_load) begin
            cnt <= CNT_LOAD;
         end else if (cnt_dec) begin
            cnt <= cnt - CNT_TC;
         end
      end
   end

   // din still holds the right-aligned store data while the read is outstanding.
   ram_lane_align u_align (
      .size      (lat_size),
      .offset    (lat_off),
      .sign_ext  (lat_signed),
      .word      (out),
      .wdata     (din),
      .load_data (load_data),
      .merged    (merged)
   );

endmodule

// File: tb/tb_bram_lsu.sv
// Directed and randomized checks of bram_lsu against a word-array reference model.
module tb_bram_lsu;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [16:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [14:0] addr;
   logic [31:0] din;
   logic        we;
   logic        startReadRAM;
   logic [31:0] rdata_q = '0;
   logic        rd_rdy = 1'b1;
   logic        sv_rdy = 1'b1;

   bit [31:0]   ram     [0:32767];
   bit [31:0]   ref_mem [0:32767];
   int          we_cnt = 0;
   int          sr_cnt = 0;
   int          rv_cnt = 0;
   logic [14:0] last_we_addr = '0;
   logic [31:0] last_we_din = '0;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   bram_lsu #(.BLOCKS(14), .TIMEOUT(15)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_signed   (req_signed),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .addr         (addr),
      .din          (din),
      .we           (we),
      .startReadRAM (startReadRAM),
      .out          (rdata_q),
      .readRdyRAM   (rd_rdy),
      .saveRdyRAM   (sv_rdy)
   );

   // BRAM model: registered read launched by startReadRAM, write on we.
   always @(posedge clk) begin
      if (we) begin
         ram[addr] <= din;
         we_cnt++;
         last_we_addr = addr;
         last_we_din  = din;
      end
      if (startReadRAM) begin
         rdata_q <= ram[addr];
         sr_cnt++;
      end
      if (resp_valid) rv_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic req_bad(input logic [1:0] sz, input logic [16:0] a);
      return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
             || (int'(a >> 2) >= 14 * 256);
   endfunction

   function automatic int size_bits(input logic [1:0] sz);
      return (sz == 2'b00) ? 8 : (sz == 2'b01) ? 16 : 32;
   endfunction

   function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] sz,
                                            input logic sg, input int off);
      int nb;
      logic [31:0] m, v;
      nb = size_bits(sz);
      if (nb == 32) return w;
      m = (32'd1 << nb) - 32'd1;
      v = (w >> (8 * off)) & m;
      if (sg && v[nb-1]) v = v | ~m;
      return v;
   endfunction

   function automatic logic [31:0] store_val(input logic [31:0] w, input logic [1:0] sz,
                                             input int off, input logic [31:0] wd);
      int nb;
      logic [31:0] m;
      nb = size_bits(sz);
      if (nb == 32) return wd;
      m = ((32'd1 << nb) - 32'd1) << (8 * off);
      return (w & ~m) | ((wd << (8 * off)) & m);
   endfunction

   // rh/sh: readRdyRAM/saveRdyRAM held low for that many cycles after acceptance.
   task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input logic [16:0] a,
                         input logic [31:0] wd, input int rh, input int sh);
      logic        bad, exp_err;
      logic [31:0] old_w, exp_rd, exp_din;
      int          exp_lat, exp_we, exp_sr, waits, lat, we0, sr0, off;
      bit          got;
      off     = int'(a[1:0]);
      bad     = req_bad(sz, a);
      old_w   = ref_mem[a[16:2]];
      exp_rd  = '0;
      exp_err = bad;
      exp_we  = 0;
      exp_sr  = 0;
      exp_din = '0;
      exp_lat = 1;
      if (!bad) begin
         if (!w) begin
            exp_sr = 1;
            waits  = (rh > 0) ? rh - 1 : 0;
            if (waits >= 15) begin
               exp_err = 1'b1;
               exp_lat = 2 + 15;
            end else begin
               exp_lat = 3 + waits;
               exp_rd  = load_val(old_w, sz, sg, off);
            end
         end else if (sz == 2'b10) begin
            waits = sh;
            if (waits >= 15) begin
               exp_err = 1'b1;
               exp_lat = 1 + 15;
            end else begin
               exp_lat = 2 + waits;
               exp_we  = 1;
               exp_din = wd;
            end
         end else begin
            exp_sr  = 1;
            exp_lat = 4;
            exp_we  = 1;
            exp_din = store_val(old_w, sz, off, wd);
         end
      end

      @(negedge clk);
      rd_rdy     = (rh == 0);
      sv_rdy     = (sh == 0);
      req_valid  = 1'b1;
      req_we     = w;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      we0        = we_cnt;
      sr0        = sr_cnt;
      #1 check("ready_before_accept", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      lat = 0;
      got = 0;
      while (!got && lat < 40) begin
         @(negedge clk);
         lat++;
         req_valid  = 1'b0;
         req_we     = 1'($urandom);
         req_size   = 2'($urandom);
         req_signed = 1'($urandom);
         req_addr   = 17'($urandom);
         req_wdata  = $urandom;
         rd_rdy     = (lat > rh);
         sv_rdy     = (lat > sh);
         if (resp_valid) got = 1;
      end
      check("resp_seen", {31'b0, got}, 32'd1);
      check("latency", lat, exp_lat);
      check("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
      check("resp_rdata", resp_rdata, exp_rd);
      check("ready_in_resp", {31'b0, req_ready}, 32'd1);
      rd_rdy = 1'b1;
      sv_rdy = 1'b1;
      check("we_pulses", we_cnt - we0, exp_we);
      check("start_pulses", sr_cnt - sr0, exp_sr);
      if (exp_we == 1) begin
         check("we_addr", {17'b0, last_we_addr}, {17'b0, a[16:2]});
         check("we_din", last_we_din, exp_din);
         ref_mem[a[16:2]] = exp_din;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int we0, rv0;
      logic w;
      logic [1:0] sz;
      logic [16:0] a;
      int rh, sh;

      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_addr", {17'b0, addr}, 32'd0);
      check("rst_din", din, 32'd0);
      check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("rst_resp_err", {31'b0, resp_err}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_start", {31'b0, startReadRAM}, 32'd0);
      check("rst_ready_low", {31'b0, req_ready}, 32'd0);
      check("rst_we", {31'b0, we}, 32'd0);
      rst = 1'b1;

      do_req(1'b1, 2'b10, 1'b0, 17'h00010, 32'hDEADBEEF, 0, 0);
      do_req(1'b0, 2'b10, 1'b0, 17'h00010, 32'h0, 0, 0);
      do_req(1'b1, 2'b00, 1'b0, 17'h00013, 32'h0000007F, 0, 0);
      do_req(1'b1, 2'b00, 1'b0, 17'h00012, 32'hFFFFFF80, 0, 0);
      do_req(1'b0, 2'b00, 1'b1, 17'h00012, 32'h0, 0, 0);
      do_req(1'b0, 2'b00, 1'b0, 17'h00012, 32'h0, 0, 0);
      do_req(1'b0, 2'b01, 1'b1, 17'h00012, 32'h0, 0, 0);
      do_req(1'b0, 2'b01, 1'b1, 17'h00010, 32'h0, 0, 0);
      do_req(1'b1, 2'b01, 1'b0, 17'h00010, 32'h12341234, 0, 0);
      do_req(1'b0, 2'b10, 1'b0, 17'h00010, 32'h0, 0, 0);

      do_req(1'b0, 2'b01, 1'b0, 17'h00011, 32'h0, 0, 0);
      do_req(1'b0, 2'b11, 1'b0, 17'h00010, 32'h0, 0, 0);
      do_req(1'b0, 2'b10, 1'b0, 17'h0E000, 32'h0, 0, 0);
      do_req(1'b1, 2'b00, 1'b0, 17'h0E000, 32'h55, 0, 0);
      do_req(1'b1, 2'b10, 1'b0, 17'h00016, 32'h1, 0, 0);
      do_req(1'b1, 2'b10, 1'b0, 17'h0DFFC, 32'hCAFEF00D, 0, 0);
      do_req(1'b0, 2'b10, 1'b0, 17'h0DFFC, 32'h0, 0, 0);

      do_req(1'b0, 2'b10, 1'b0, 17'h00010, 32'h0, 20, 0);
      do_req(1'b0, 2'b10, 1'b0, 17'h00010, 32'h0, 16, 0);
      do_req(1'b0, 2'b10, 1'b0, 17'h00010, 32'h0, 15, 0);
      do_req(1'b0, 2'b00, 1'b1, 17'h00013, 32'h0, 5, 0);
      do_req(1'b1, 2'b10, 1'b0, 17'h00020, 32'h0BADF00D, 0, 3);
      do_req(1'b1, 2'b10, 1'b0, 17'h00024, 32'h11111111, 0, 20);
      do_req(1'b1, 2'b10, 1'b0, 17'h00024, 32'h22222222, 0, 15);
      do_req(1'b1, 2'b10, 1'b0, 17'h00024, 32'h33333333, 0, 14);

      // Reset landing in RD_WAIT of a byte store must drop the transaction.
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'b00;
      req_addr  = 17'h00021;
      req_wdata = 32'h000000A5;
      we0       = we_cnt;
      rv0       = rv_cnt;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_addr", {17'b0, addr}, 32'd0);
      rst = 1'b1;
      #1 check("ready_after_release", {31'b0, req_ready}, 32'd1);
      repeat (4) @(negedge clk);
      check("midrst_no_we", we_cnt - we0, 0);
      check("midrst_no_resp", rv_cnt - rv0, 0);
      do_req(1'b0, 2'b10, 1'b0, 17'h00020, 32'h0, 0, 0);

      for (int i = 0; i < 200; i++) begin
         w  = 1'($urandom);
         sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         if ($urandom_range(0, 9) == 0) a = 17'($urandom_range(32'h0DFF0, 32'h0E00F));
         else a = 17'($urandom_range(0, 63));
         rh = 0;
         sh = 0;
         if (!w) rh = $urandom_range(0, 6);
         else if (sz == 2'b10) sh = $urandom_range(0, 4);
         do_req(w, sz, 1'($urandom), a, $urandom, rh, sh);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
